// File: rtl/sopc_nios2_oci_trace_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sopc_nios2_oci_trace_pkg
// Description : Shared state encodings and widths for the OCI trace capture.
// Revision    : 1.0 - initial release
// ============================================================================
package sopc_nios2_oci_trace_pkg;

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_capture = 2'd1;
    localparam logic [1:0] c_st_drain   = 2'd2;
    localparam logic [1:0] c_st_done    = 2'd3;

    localparam int c_def_data_w = 30;
    localparam int c_def_cnt_w  = 4;
    localparam int c_entry_w    = c_def_cnt_w + c_def_data_w;
    localparam int c_ovf_w      = 16;

    function automatic int entry_width(input int cnt_w, input int data_w);
        return cnt_w + data_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sopc_nios2_oci_trace_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sopc_nios2_oci_trace_fifo
// Description : Synchronous FIFO with registered one-cycle read port.
// Revision    : 1.0 - initial release
// ============================================================================
module sopc_nios2_oci_trace_fifo
    import sopc_nios2_oci_trace_pkg::*;
#(
    parameter int WIDTH = c_entry_w,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     rvalid,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int c_aw = $clog2(DEPTH);
    localparam logic [c_aw:0] c_one = (c_aw+1)'(1);

    logic [WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [c_aw:0]    r_wr_ptr;
    logic [c_aw:0]    r_rd_ptr;
    logic [c_aw:0]    r_level;
    logic [WIDTH-1:0] r_rdata;
    logic             r_rvalid;
    logic             w_do_push;
    logic             w_do_pop;

    assign full  = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                   (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
    assign empty = (r_wr_ptr == r_rd_ptr);

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push
    assign w_do_pop  = pop && !empty && !clr;
    assign w_do_push = push && !clr && (!full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[c_aw-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else if (clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= w_do_pop;
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_one;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_one;
                r_rdata  <= r_mem[r_rd_ptr[c_aw-1:0]];
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + c_one;
                2'b01:   r_level <= r_level - c_one;
                default: r_level <= r_level;
            endcase
        end
    end

    assign rdata  = r_rdata;
    assign rvalid = r_rvalid;
    assign level  = r_level;

endmodule
`default_nettype wire

// File: rtl/sopc_nios2_oci_trace_capture.sv
`default_nettype none
// ============================================================================
// Module      : sopc_nios2_oci_trace_capture
// Description : Packs completed DCT trace words into a FIFO with drain/done.
// Revision    : 1.0 - initial release
// ============================================================================
module sopc_nios2_oci_trace_capture
    import sopc_nios2_oci_trace_pkg::*;
#(
    parameter int DATA_W     = 30,
    parameter int CNT_W      = 4,
    parameter int FULL_COUNT = 3,
    parameter int DEPTH      = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [DATA_W-1:0]         dct_buffer,
    input  logic [CNT_W-1:0]          dct_count,
    input  logic                      test_ending,
    input  logic                      test_has_ended,
    input  logic                      arm,
    input  logic                      rd_req,
    output logic [CNT_W+DATA_W-1:0]   rd_data,
    output logic                      rd_valid,
    output logic [$clog2(DEPTH):0]    level,
    output logic [c_ovf_w-1:0]        overflow_cnt,
    output logic                      capturing,
    output logic                      done
);

    localparam int                 c_entry_w_top = entry_width(CNT_W, DATA_W);
    localparam logic [CNT_W-1:0]   c_full_cnt    = CNT_W'(FULL_COUNT);
    localparam logic [c_ovf_w-1:0] c_ovf_max     = '1;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [CNT_W-1:0]    r_prev_count;
    logic                r_test_ending_d;
    logic                r_capturing;
    logic                r_done;
    logic [c_ovf_w-1:0]  r_ovf_cnt;
    logic                w_te_rise;
    logic                w_full_word;
    logic                w_push;
    logic                w_clr;
    logic                w_drop;
    logic                w_fifo_full;
    logic                w_fifo_empty;

    assign w_te_rise   = test_ending && !r_test_ending_d;
    assign w_full_word = (dct_count == c_full_cnt) && (r_prev_count != c_full_cnt);
    // Full means non-empty, so any real pop makes room for this push
    assign w_drop      = w_push && w_fifo_full && !(rd_req && !w_fifo_empty);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= c_st_idle;
            r_prev_count    <= '0;
            r_test_ending_d <= 1'b0;
            r_capturing     <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_prev_count    <= dct_count;
            r_test_ending_d <= test_ending;
            r_capturing     <= (w_state_nxt == c_st_capture);
            r_done          <= (w_state_nxt == c_st_done);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle, c_st_done: begin
                if (arm) w_state_nxt = c_st_capture;
            end
            c_st_capture: begin
                if (w_te_rise || test_has_ended) w_state_nxt = c_st_drain;
            end
            c_st_drain: begin
                if (test_has_ended && (level == '0)) w_state_nxt = c_st_done;
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    // The partial flush only fires when no full-word push claims the cycle
    always_comb begin
        w_clr  = 1'b0;
        w_push = 1'b0;
        if (((r_state == c_st_idle) || (r_state == c_st_done)) && arm) begin
            w_clr = 1'b1;
        end
        if (r_state == c_st_capture) begin
            w_push = w_full_word || (w_te_rise && (dct_count != '0));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ovf_cnt <= '0;
        end else if (w_clr) begin
            r_ovf_cnt <= '0;
        end else if (w_drop && (r_ovf_cnt != c_ovf_max)) begin
            r_ovf_cnt <= r_ovf_cnt + c_ovf_w'(1);
        end
    end

    sopc_nios2_oci_trace_fifo #(
        .WIDTH (c_entry_w_top),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (w_clr),
        .push    (w_push),
        .pop     (rd_req),
        .wdata   ({dct_count, dct_buffer}),
        .rdata   (rd_data),
        .rvalid  (rd_valid),
        .level   (level),
        .full    (w_fifo_full),
        .empty   (w_fifo_empty)
    );

    assign overflow_cnt = r_ovf_cnt;
    assign capturing    = r_capturing;
    assign done         = r_done;

endmodule
`default_nettype wire

// File: tb/tb_sopc_nios2_oci_trace_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_sopc_nios2_oci_trace_capture
// Description : Table, directed and random checks against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sopc_nios2_oci_trace_capture;

    localparam int DATA_W     = 30;
    localparam int CNT_W      = 4;
    localparam int FULL_COUNT = 3;
    localparam int DEPTH      = 16;
    localparam int EW         = CNT_W + DATA_W;
    localparam int LW         = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [DATA_W-1:0] dct_buffer = '0;
    logic [CNT_W-1:0]  dct_count = '0;
    logic              test_ending = 1'b0;
    logic              test_has_ended = 1'b0;
    logic              arm = 1'b0;
    logic              rd_req = 1'b0;
    logic [EW-1:0]     rd_data;
    logic              rd_valid;
    logic [LW-1:0]     level;
    logic [15:0]       overflow_cnt;
    logic              capturing;
    logic              done;

    always #5 clk = ~clk;

    sopc_nios2_oci_trace_capture #(
        .DATA_W(DATA_W), .CNT_W(CNT_W), .FULL_COUNT(FULL_COUNT), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset_n(reset_n), .dct_buffer(dct_buffer), .dct_count(dct_count),
        .test_ending(test_ending), .test_has_ended(test_has_ended), .arm(arm),
        .rd_req(rd_req), .rd_data(rd_data), .rd_valid(rd_valid), .level(level),
        .overflow_cnt(overflow_cnt), .capturing(capturing), .done(done)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model: mode 0=idle 1=capture 2=drain 3=done, FIFO as a queue
    logic [EW-1:0]    m_q [$];
    int               m_ovf;
    int               m_mode;
    logic [CNT_W-1:0] m_prev;
    logic             m_prev_te;
    logic [EW-1:0]    m_rd_data;
    logic             m_rd_valid;

    function automatic void model_reset();
        m_q.delete();
        m_ovf = 0; m_mode = 0; m_prev = '0; m_prev_te = 1'b0;
        m_rd_data = '0; m_rd_valid = 1'b0;
    endfunction

    function automatic void model_step(input logic a, input logic [CNT_W-1:0] c,
                                       input logic [DATA_W-1:0] b, input logic te,
                                       input logic the, input logic rd);
        int  pre;
        bit  popping, pushing, fullw, rise;
        pre = m_q.size();
        popping = 1'b0; pushing = 1'b0;
        m_rd_valid = 1'b0;
        if ((m_mode == 0 || m_mode == 3) && a) begin
            m_q.delete();
            m_ovf = 0;
            m_mode = 1;
        end else begin
            popping = rd && (pre > 0);
            if (m_mode == 1) begin
                fullw = (c == FULL_COUNT) && (m_prev != FULL_COUNT);
                rise = te && !m_prev_te;
                pushing = fullw || (rise && c != 0);
                if (rise || the) m_mode = 2;
            end else if (m_mode == 2 && the && pre == 0) begin
                m_mode = 3;
            end
            if (popping) begin
                m_rd_data = m_q.pop_front();
                m_rd_valid = 1'b1;
            end
            if (pushing) begin
                if (pre < DEPTH || popping) m_q.push_back({c, b});
                else if (m_ovf < 65535) m_ovf++;
            end
        end
        m_prev = c;
        m_prev_te = te;
    endfunction

    task automatic step(input logic a, input logic [CNT_W-1:0] c, input logic [DATA_W-1:0] b,
                        input logic te, input logic the, input logic rd);
        arm = a; dct_count = c; dct_buffer = b;
        test_ending = te; test_has_ended = the; rd_req = rd;
        model_step(a, c, b, te, the, rd);
        @(posedge clk); #1;
        check("level", level, m_q.size());
        check("overflow_cnt", overflow_cnt, m_ovf);
        check("capturing", capturing, m_mode == 1);
        check("done", done, m_mode == 3);
        check("rd_valid", rd_valid, m_rd_valid);
        if (m_rd_valid) check("rd_data", rd_data, m_rd_data);
    endtask

    task automatic push_word(input logic [DATA_W-1:0] b);
        step(1'b0, 4'd3, b, 1'b0, 1'b0, 1'b0);
        step(1'b0, 4'd0, b, 1'b0, 1'b0, 1'b0);
    endtask

    typedef struct {
        logic a; logic [CNT_W-1:0] c; logic [DATA_W-1:0] b; logic te; logic the; logic rd;
        int e_level; logic e_valid; logic [EW-1:0] e_data; logic e_cap; logic e_done;
    } vec_t;
    vec_t tv [$];

    function automatic void add(input logic a, input logic [CNT_W-1:0] c, input logic [DATA_W-1:0] b,
                                input logic te, input logic the, input logic rd, input int lv,
                                input logic v, input logic [EW-1:0] d, input logic cp, input logic dn);
        vec_t t;
        t.a = a; t.c = c; t.b = b; t.te = te; t.the = the; t.rd = rd;
        t.e_level = lv; t.e_valid = v; t.e_data = d; t.e_cap = cp; t.e_done = dn;
        tv.push_back(t);
    endfunction

    logic te_r, the_r, ra;

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset rd_data", rd_data, 0);
        check("reset rd_valid", rd_valid, 0);
        check("reset level", level, 0);
        check("reset overflow_cnt", overflow_cnt, 0);
        check("reset capturing", capturing, 0);
        check("reset done", done, 0);
        reset_n = 1'b1;

        //   a  c     buffer        te the rd  lvl v  data                  cap done
        add(1, 4'd0, 30'h0,        0, 0, 0,  0,  0, '0,                   1, 0);
        add(0, 4'd1, 30'h1234567,  0, 0, 0,  0,  0, '0,                   1, 0);
        add(0, 4'd2, 30'h1234567,  0, 0, 0,  0,  0, '0,                   1, 0);
        add(0, 4'd3, 30'h1234567,  0, 0, 0,  1,  0, '0,                   1, 0);
        add(0, 4'd3, 30'h1234567,  0, 0, 0,  1,  0, '0,                   1, 0);
        add(0, 4'd0, 30'h1234567,  0, 0, 0,  1,  0, '0,                   1, 0);
        add(0, 4'd0, 30'h0,        0, 0, 1,  0,  1, {4'd3, 30'h1234567},  1, 0);
        add(0, 4'd0, 30'h0,        0, 0, 0,  0,  0, '0,                   1, 0);
        add(0, 4'd2, 30'hABCDE,    0, 0, 0,  0,  0, '0,                   1, 0);
        add(0, 4'd2, 30'hABCDE,    1, 0, 0,  1,  0, '0,                   0, 0);
        add(0, 4'd0, 30'h0,        1, 1, 1,  0,  1, {4'd2, 30'hABCDE},    0, 0);
        add(0, 4'd0, 30'h0,        1, 1, 0,  0,  0, '0,                   0, 1);
        add(0, 4'd0, 30'h0,        1, 1, 0,  0,  0, '0,                   0, 1);
        add(1, 4'd0, 30'h0,        0, 0, 0,  0,  0, '0,                   1, 0);
        add(0, 4'd0, 30'h0,        0, 0, 0,  0,  0, '0,                   1, 0);

        for (int i = 0; i < tv.size(); i++) begin
            step(tv[i].a, tv[i].c, tv[i].b, tv[i].te, tv[i].the, tv[i].rd);
            check($sformatf("vec%0d level", i), level, tv[i].e_level);
            check($sformatf("vec%0d rd_valid", i), rd_valid, tv[i].e_valid);
            if (tv[i].e_valid) check($sformatf("vec%0d rd_data", i), rd_data, tv[i].e_data);
            check($sformatf("vec%0d capturing", i), capturing, tv[i].e_cap);
            check($sformatf("vec%0d done", i), done, tv[i].e_done);
        end

        // Overflow: 20 words into a 16-deep FIFO
        for (int i = 0; i < 20; i++) push_word(30'h100 + 30'(i));
        check("ovf level", level, 16);
        check("ovf count", overflow_cnt, 4);

        // Push and pop together while full
        step(1'b0, 4'd3, 30'h200, 1'b0, 1'b0, 1'b1);
        check("full pushpop level", level, 16);
        check("full pushpop ovf", overflow_cnt, 4);
        check("full pushpop data", rd_data, {4'd3, 30'h100});
        for (int k = 1; k <= 16; k++) begin
            step(1'b0, 4'd0, 30'h0, 1'b0, 1'b0, 1'b1);
            check($sformatf("order%0d", k), rd_data, (k < 16) ? {4'd3, 30'h100 + 30'(k)} : {4'd3, 30'h200});
        end
        step(1'b0, 4'd0, 30'h0, 1'b0, 1'b0, 1'b1);
        check("empty pop rd_valid", rd_valid, 0);

        for (int i = 0; i < 5; i++) push_word(30'h300 + 30'(i));
        step(1'b1, 4'd0, 30'h0, 1'b0, 1'b0, 1'b0);
        check("arm in capture level", level, 5);
        check("arm in capture capturing", capturing, 1);
        push_word(30'h305);
        push_word(30'h306);
        check("pre-reset level", level, 7);

        // Asynchronous reset mid-cycle
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check("async rst level", level, 0);
        check("async rst rd_valid", rd_valid, 0);
        check("async rst rd_data", rd_data, 0);
        check("async rst capturing", capturing, 0);
        check("async rst done", done, 0);
        check("async rst ovf", overflow_cnt, 0);
        arm = 1'b0; dct_count = '0; test_ending = 1'b0; test_has_ended = 1'b0; rd_req = 1'b0;
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        check("post rst capturing", capturing, 0);
        check("post rst level", level, 0);
        step(1'b0, 4'd3, 30'h1, 1'b0, 1'b0, 1'b0);
        check("post rst idle no push", level, 0);

        // Randomized traffic against the model
        te_r = 1'b0; the_r = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            ra = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 29) == 0) te_r = ~te_r;
            if ($urandom_range(0, 39) == 0) the_r = ~the_r;
            step(ra, CNT_W'($urandom_range(0, 3)), DATA_W'($urandom), te_r, the_r,
                 !ra && ($urandom_range(0, 2) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
